// File: rtl/ssp_tx_fifo_p.sv
// SSP transmit FIFO: circular buffer with first-word-fall-through head, occupancy count,
// watermark interrupt and sticky overrun/underrun flags.
module ssp_tx_fifo_p #(
  parameter int unsigned  DATA_W = 8,
  parameter int unsigned  DEPTH  = 8,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              PCLK,
  input  logic              CLEAR,
  input  logic              PSEL,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic              fin,
  input  logic              TXIM,
  input  logic [CNT_W-1:0]  TxLevel,
  input  logic              ERR_CLR,
  output logic [DATA_W-1:0] TxData,
  output logic              validTx,
  output logic              TxFull,
  output logic              SSPTXINTR,
  output logic [CNT_W-1:0]  TxCount,
  output logic              TxOverrun,
  output logic              TxUnderrun
);

  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovr_q, ovr_d;
  logic              und_q, und_d;

  logic push, empty, full, pop_ok, push_ok;

  always_comb begin
    push    = PSEL & PWRITE;
    empty   = (count_q == '0);
    full    = (count_q == FullCnt);
    pop_ok  = fin & ~empty;
    // At full a push is still taken if the head leaves in the same cycle.
    push_ok = push & (~full | pop_ok);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);

    // New errors win over ERR_CLR in the same cycle.
    ovr_d = (ovr_q & ~ERR_CLR) | (push & full & ~fin);
    und_d = (und_q & ~ERR_CLR) | (fin & empty);
  end

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      und_q    <= und_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!CLEAR && push_ok) mem_q[wr_ptr_q] <= PWDATA;
  end

  assign TxData     = empty ? '0 : mem_q[rd_ptr_q];
  assign validTx    = ~empty;
  assign TxFull     = full;
  assign TxCount    = count_q;
  assign TxOverrun  = ovr_q;
  assign TxUnderrun = und_q;
  assign SSPTXINTR  = TXIM & (count_q <= TxLevel);

endmodule

// File: tb/tb_ssp_tx_fifo_p.sv
// Table-driven bench for ssp_tx_fifo_p at default parameters (8 x 8).
module tb_ssp_tx_fifo_p;

  logic       clk = 1'b0;
  logic       clear, psel, pwrite, fin, txim, err_clr;
  logic [7:0] pwdata;
  logic [3:0] txlevel;
  logic [7:0] tx_data;
  logic       valid_tx, tx_full, intr, ovr, und;
  logic [3:0] tx_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ssp_tx_fifo_p dut (
    .PCLK      (clk),
    .CLEAR     (clear),
    .PSEL      (psel),
    .PWRITE    (pwrite),
    .PWDATA    (pwdata),
    .fin       (fin),
    .TXIM      (txim),
    .TxLevel   (txlevel),
    .ERR_CLR   (err_clr),
    .TxData    (tx_data),
    .validTx   (valid_tx),
    .TxFull    (tx_full),
    .SSPTXINTR (intr),
    .TxCount   (tx_count),
    .TxOverrun (ovr),
    .TxUnderrun(und)
  );

  typedef struct {
    bit         clr;
    bit         wr;
    logic [7:0] d;
    bit         f;
    bit         ec;
    bit         im;
    logic [3:0] lvl;
    int         cnt;
    logic [7:0] ed;
    bit         eo;
    bit         eu;
    bit         ei;
    bit         comb;  // also check that dropping TXIM kills the interrupt without a clock
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit clr, input bit wr, input logic [7:0] d, input bit f,
                     input bit ec, input bit im, input logic [3:0] lvl, input int cnt,
                     input logic [7:0] ed, input bit eo, input bit eu, input bit ei,
                     input bit comb = 1'b0);
    vec_t v;
    v.clr = clr; v.wr = wr; v.d = d; v.f = f; v.ec = ec; v.im = im; v.lvl = lvl;
    v.cnt = cnt; v.ed = ed; v.eo = eo; v.eu = eu; v.ei = ei; v.comb = comb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL row %0d %s: got %0h expected %0h", idx, name, act, exp);
    end
  endtask

  initial begin
    clear = 1'b1; psel = 1'b0; pwrite = 1'b0; pwdata = '0; fin = 1'b0;
    txim = 1'b0; txlevel = '0; err_clr = 1'b0;

    // 1: reset, then fill with A1..A8
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 8; i++) add(0, 1, 8'hA1 + 8'(i), 0, 0, 0, 0, i + 1, 8'hA1, 0, 0, 0);
    // 2: overflow is dropped, drain, clear flag
    add(0, 1, 8'hFF, 0, 0, 0, 0, 8, 8'hA1, 1, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 8'h00, 1, 0, 0, 0, 7 - i, 8'hA2 + 8'(i), 1, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    // 3: refill, push+pop at full, write pointer wraps
    for (int i = 0; i < 8; i++) add(0, 1, 8'hA1 + 8'(i), 0, 0, 0, 0, i + 1, 8'hA1, 0, 0, 0);
    add(0, 1, 8'h55, 1, 0, 0, 0, 8, 8'hA2, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 0, 8'h00, 1, 0, 0, 0, 7 - i, 8'hA3 + 8'(i), 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h55, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    // 4: underrun cases
    add(0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 1, 8'h3C, 1, 0, 0, 0, 1, 8'h3C, 0, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    // 5: watermark interrupt, TxLevel=2
    add(0, 1, 8'h01, 0, 0, 1, 2, 1, 8'h01, 0, 0, 1);
    add(0, 1, 8'h02, 0, 0, 1, 2, 2, 8'h01, 0, 0, 1);
    add(0, 1, 8'h03, 0, 0, 1, 2, 3, 8'h01, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 2, 3, 8'h01, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 1, 2, 2, 8'h02, 0, 0, 1, 1);
    add(0, 0, 8'h00, 0, 0, 0, 2, 2, 8'h02, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 2, 1, 8'h03, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 2, 0, 8'h00, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 1);
    // 6: count 5 with overrun set, CLEAR beats push/fin, pointers restart
    for (int i = 0; i < 8; i++) add(0, 1, 8'hC0 + 8'(i), 0, 0, 0, 0, i + 1, 8'hC0, 0, 0, 0);
    add(0, 1, 8'hFF, 0, 0, 0, 0, 8, 8'hC0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 1, 0, 0, 0, 7 - i, 8'hC1 + 8'(i), 1, 0, 0);
    add(1, 1, 8'h77, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 1, 8'h11, 0, 0, 0, 0, 1, 8'h11, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      clear = vecs[i].clr; psel = vecs[i].wr; pwrite = vecs[i].wr; pwdata = vecs[i].d;
      fin = vecs[i].f; err_clr = vecs[i].ec; txim = vecs[i].im; txlevel = vecs[i].lvl;
      @(posedge clk);
      #1;
      chk("count", i, 32'(tx_count), 32'(vecs[i].cnt));
      chk("data", i, 32'(tx_data), 32'(vecs[i].ed));
      chk("valid", i, 32'(valid_tx), 32'(vecs[i].cnt != 0));
      chk("full", i, 32'(tx_full), 32'(vecs[i].cnt == 8));
      chk("overrun", i, 32'(ovr), 32'(vecs[i].eo));
      chk("underrun", i, 32'(und), 32'(vecs[i].eu));
      chk("intr", i, 32'(intr), 32'(vecs[i].ei));
      if (vecs[i].comb) begin
        txim = 1'b0;
        #1;
        chk("intr_comb_off", i, 32'(intr), 32'd0);
        txim = 1'b1;
        #1;
        chk("intr_comb_on", i, 32'(intr), 32'd1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
